// File: rtl/mnemonic_decoder_if.sv
// Link-side signal bundle for mnemonic_decoder: the sample strobe, the serial bit,
// and the lock/identification results flowing back to the consumer.
interface mnemonic_decoder_if;
  logic        bit_en;
  logic        seq_in;
  logic [1:0]  pattern_id;
  logic        locked;
  logic        id_valid;
  logic        lost;
  logic [15:0] err_count;

  modport master (
    output bit_en, seq_in,
    input  pattern_id, locked, id_valid, lost, err_count
  );

  modport slave (
    input  bit_en, seq_in,
    output pattern_id, locked, id_valid, lost, err_count
  );
endinterface

// File: rtl/mnemonic_decoder.sv
// Serial-link receiver: identifies which of four stored frames repeats in seq_in and
// tracks its frame phase. Optional feature macro: MNEMONIC_DECODER_ERR_COUNT_EN.
module mnemonic_decoder #(
  parameter int               PAT_W      = 8,
  parameter logic [PAT_W-1:0] PAT0       = 8'hB2,
  parameter logic [PAT_W-1:0] PAT1       = 8'h5C,
  parameter logic [PAT_W-1:0] PAT2       = 8'hE1,
  parameter logic [PAT_W-1:0] PAT3       = 8'h3A,
  parameter int               LOCK_COUNT = 2,
  parameter int               MISS_LIMIT = 2
) (
  input  logic               clk,
  input  logic               reset,
  mnemonic_decoder_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int POS_W  = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PAT_W - 1);
  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(MISS_LIMIT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    sr_q, sr_d, sr_next;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_next;
  logic [POS_W-1:0]    pos_q, pos_d, pos_inc;
  logic [1:0]          cand_q, cand_d;
  logic [1:0]          pid_q, pid_d;
  logic [HIT_W-1:0]    hits_q, hits_d, hits_inc;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                locked_q, locked_d;
  logic                idv_q, idv_d;
  logic                lost_q, lost_d;
  logic                err_inc;
  logic                full;
  logic                boundary;
  logic [3:0]          match;

  // Lowest index wins when more than one stored frame matches the window.
  function automatic logic [1:0] first_idx(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    sr_next   = {sr_q[PAT_W-2:0], bus.seq_in};
    fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    full      = (fill_next == FILL_FULL);
    match     = '0;
    if (full) begin
      match = {sr_next == PAT3, sr_next == PAT2, sr_next == PAT1, sr_next == PAT0};
    end
    boundary  = (pos_q == POS_LAST);
    pos_inc   = boundary ? '0 : pos_q + POS_W'(1);
    hits_inc  = hits_q + HIT_W'(1);
    miss_inc  = miss_q + MISS_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    fill_d   = fill_q;
    pos_d    = pos_q;
    cand_d   = cand_q;
    pid_d    = pid_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    idv_d    = 1'b0;
    lost_d   = 1'b0;
    err_inc  = 1'b0;

    if (bus.bit_en) begin
      sr_d   = sr_next;
      fill_d = fill_next;
      unique case (state_q)
        SEARCH: begin
          if (|match) begin
            cand_d = first_idx(match);
            hits_d = HIT_W'(1);
            pos_d  = '0;
            if (LOCK_COUNT == 1) begin
              state_d  = LOCKED;
              pid_d    = first_idx(match);
              locked_d = 1'b1;
              idv_d    = 1'b1;
              miss_d   = '0;
            end else begin
              state_d = CONFIRM;
            end
          end
        end

        CONFIRM: begin
          pos_d = pos_inc;
          // A failed boundary drops to SEARCH; this same bit is not re-examined.
          if (boundary) begin
            if (match[cand_q]) begin
              hits_d = hits_inc;
              if (hits_inc == HIT_LOCK) begin
                state_d  = LOCKED;
                pid_d    = cand_q;
                locked_d = 1'b1;
                idv_d    = 1'b1;
                miss_d   = '0;
              end
            end else begin
              state_d = SEARCH;
            end
          end
        end

        LOCKED: begin
          pos_d = pos_inc;
          if (boundary) begin
            if (match[pid_q]) begin
              miss_d = '0;
            end else begin
              err_inc = 1'b1;
              miss_d  = miss_inc;
              if (miss_inc == MISS_DROP) begin
                state_d  = SEARCH;
                locked_d = 1'b0;
                lost_d   = 1'b1;
                hits_d   = '0;
                miss_d   = '0;
              end
            end
          end
        end

        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      fill_q   <= '0;
      pos_q    <= '0;
      cand_q   <= '0;
      pid_q    <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      idv_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      pos_q    <= pos_d;
      cand_q   <= cand_d;
      pid_q    <= pid_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      idv_q    <= idv_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.pattern_id = pid_q;
  assign bus.locked     = locked_q;
  assign bus.id_valid   = idv_q;
  assign bus.lost       = lost_q;

`ifdef MNEMONIC_DECODER_ERR_COUNT_EN
  logic [15:0] err_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Survives loss of lock; only reset clears the mismatch history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (err_inc) begin
      err_q <= sat_inc16(err_q);
    end
  end

  assign bus.err_count = err_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign bus.err_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_mnemonic_decoder.sv
// Self-checking bench for mnemonic_decoder: directed scenarios plus random streams,
// all compared against a frame-level reference model built on the received bit history.
module tb_mnemonic_decoder;
  localparam int PAT_W      = 8;
  localparam int LOCK_COUNT = 2;
  localparam int MISS_LIMIT = 2;
`ifdef MNEMONIC_DECODER_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  mnemonic_decoder_if bus ();

  mnemonic_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] pats [4] = '{8'hB2, 8'h5C, 8'hE1, 8'h3A};

  int n_vec = 0;
  int n_err = 0;

  logic [20:0] obs;
  assign obs = {bus.pattern_id, bus.locked, bus.id_valid, bus.lost, bus.err_count};

  // Reference model: whole bit history, frame boundaries by modulo arithmetic.
  bit hist[$];
  int nbits, m_mode, m_anchor, m_cand, m_hits, m_miss, m_pid, m_err;
  bit m_locked, e_idv, e_lost;

  task automatic model_reset();
    hist.delete();
    nbits = 0; m_mode = 0; m_anchor = 0; m_cand = 0; m_hits = 0;
    m_miss = 0; m_pid = 0; m_err = 0; m_locked = 0; e_idv = 0; e_lost = 0;
  endtask

  function automatic bit mmatch(int idx);
    int w;
    if (nbits < PAT_W) return 1'b0;
    w = 0;
    for (int k = 0; k < PAT_W; k++) w = (w << 1) | int'(hist[nbits - PAT_W + k]);
    return w == int'(pats[idx]);
  endfunction

  task automatic model_step(input bit en, input bit b);
    bit found;
    bit at_frame_end;
    e_idv = 0; e_lost = 0;
    if (en) begin
      hist.push_back(b);
      nbits++;
      at_frame_end = ((nbits - m_anchor) % PAT_W) == 0;
      if (m_mode == 0) begin
        found = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && mmatch(i)) begin
            found = 1; m_cand = i; m_anchor = nbits; m_hits = 1;
          end
        end
        if (found) begin
          if (m_hits >= LOCK_COUNT) begin
            m_mode = 2; m_pid = m_cand; m_locked = 1; e_idv = 1; m_miss = 0;
          end else m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (at_frame_end) begin
          if (mmatch(m_cand)) begin
            m_hits++;
            if (m_hits == LOCK_COUNT) begin
              m_mode = 2; m_pid = m_cand; m_locked = 1; e_idv = 1; m_miss = 0;
            end
          end else m_mode = 0;
        end
      end else begin
        if (at_frame_end) begin
          if (mmatch(m_pid)) m_miss = 0;
          else begin
            m_miss++;
            if (m_err < 65535) m_err++;
            if (m_miss == MISS_LIMIT) begin
              m_mode = 0; m_locked = 0; e_lost = 1; m_miss = 0;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [20:0] exp_vec();
    logic [15:0] e;
    e = ERR_EN ? 16'(m_err) : 16'h0000;
    return {2'(m_pid), m_locked, e_idv, e_lost, e};
  endfunction

  task automatic step(input bit en, input bit b);
    bus.bit_en = en;
    bus.seq_in = b;
    @(posedge clk);
    #1;
    model_step(en, b);
  endtask

  task automatic do_reset();
    bus.bit_en = 0; bus.seq_in = 0;
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    bus.bit_en = 0; bus.seq_in = 0; reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== 21'h0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs, 21'h0);
    end
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      step(0, 1);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL reset_idle c%0d: got %h want %h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_clean_lock();
    int lock_edge = -1;
    do_reset();
    for (int e = 1; e <= 3 * PAT_W; e++) begin
      step(1, pats[0][PAT_W - 1 - ((e - 1) % PAT_W)]);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL clean_lock e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (bus.id_valid && lock_edge < 0) lock_edge = e;
    end
    n_vec++;
    if (lock_edge !== 16) begin
      n_err++; $display("FAIL clean_lock_edge: got %0d want 16", lock_edge);
    end
    n_vec++;
    if (bus.pattern_id !== 2'd0 || bus.locked !== 1'b1) begin
      n_err++; $display("FAIL clean_lock_id: got %0d/%b want 0/1", bus.pattern_id, bus.locked);
    end
  endtask

  task automatic test_misaligned();
    int lock_edge = -1;
    do_reset();
    for (int e = 1; e <= 3 + 3 * PAT_W; e++) begin
      step(1, (e <= 3) ? 1'b0 : pats[2][PAT_W - 1 - ((e - 4) % PAT_W)]);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL misaligned e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (bus.id_valid && lock_edge < 0) lock_edge = e;
    end
    n_vec++;
    if (lock_edge !== 19 || bus.pattern_id !== 2'd2) begin
      n_err++; $display("FAIL misaligned_lock: got edge %0d id %0d want edge 19 id 2", lock_edge, bus.pattern_id);
    end
  endtask

  task automatic test_pattern_change();
    int lost_edge = -1, relock_edge = -1, lost_cnt = 0;
    int want_err;
    do_reset();
    for (int e = 1; e <= 9 * PAT_W; e++) begin
      step(1, (e <= 3 * PAT_W) ? pats[1][PAT_W - 1 - ((e - 1) % PAT_W)]
                               : pats[3][PAT_W - 1 - ((e - 1) % PAT_W)]);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL pattern_change e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (bus.lost) begin lost_cnt++; if (lost_edge < 0) lost_edge = e; end
      if (bus.id_valid && lost_edge > 0 && relock_edge < 0) relock_edge = e;
    end
    want_err = ERR_EN ? 2 : 0;
    n_vec++;
    if (lost_edge !== 40 || lost_cnt !== 1) begin
      n_err++; $display("FAIL change_lost: got edge %0d count %0d want edge 40 count 1", lost_edge, lost_cnt);
    end
    n_vec++;
    if (relock_edge !== 56 || bus.pattern_id !== 2'd3) begin
      n_err++; $display("FAIL change_relock: got edge %0d id %0d want edge 56 id 3", relock_edge, bus.pattern_id);
    end
    n_vec++;
    if (int'(bus.err_count) !== want_err) begin
      n_err++; $display("FAIL change_err: got %0d want %0d", bus.err_count, want_err);
    end
  endtask

  task automatic test_corrupt_frame();
    int lost_cnt = 0, unlock_cnt = 0;
    int want_err;
    bit b;
    do_reset();
    for (int e = 1; e <= 6 * PAT_W; e++) begin
      b = pats[0][PAT_W - 1 - ((e - 1) % PAT_W)];
      if (e == 20) b = ~b;
      step(1, b);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL corrupt e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (bus.lost) lost_cnt++;
      if (e > 16 && !bus.locked) unlock_cnt++;
    end
    want_err = ERR_EN ? 1 : 0;
    n_vec++;
    if (lost_cnt !== 0 || unlock_cnt !== 0) begin
      n_err++; $display("FAIL corrupt_lock: got lost %0d unlocked %0d want 0 0", lost_cnt, unlock_cnt);
    end
    n_vec++;
    if (int'(bus.err_count) !== want_err) begin
      n_err++; $display("FAIL corrupt_err: got %0d want %0d", bus.err_count, want_err);
    end
  endtask

  task automatic test_gating();
    int lock_clk = -1, strobes = 0;
    bit en, b;
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      en = (c % 3) == 0;
      b  = en ? pats[3][PAT_W - 1 - (strobes % PAT_W)] : 1'($urandom_range(0, 1));
      if (en) strobes++;
      step(en, b);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL gating c%0d: got %h want %h", c, obs, exp_vec());
      end
      if (bus.id_valid && lock_clk < 0) lock_clk = c;
    end
    n_vec++;
    if (lock_clk !== 48 || bus.pattern_id !== 2'd3) begin
      n_err++; $display("FAIL gating_lock: got clk %0d id %0d want clk 48 id 3", lock_clk, bus.pattern_id);
    end
  endtask

  task automatic test_reset_mid();
    int lock_edge = -1;
    bit b;
    do_reset();
    for (int e = 1; e <= 12; e++) step(1, pats[0][PAT_W - 1 - ((e - 1) % PAT_W)]);
    #2 reset = 1;
    #1;
    model_reset();
    n_vec++;
    if (obs !== 21'h0) begin
      n_err++; $display("FAIL reset_confirm: got %h want %h", obs, 21'h0);
    end
    reset = 0;
    for (int e = 1; e <= 5 * PAT_W; e++) begin
      b = pats[2][PAT_W - 1 - ((e - 1) % PAT_W)];
      if (e == 27) b = ~b;
      step(1, b);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL reset_relock e%0d: got %h want %h", e, obs, exp_vec());
      end
      if (bus.id_valid && lock_edge < 0) lock_edge = e;
    end
    n_vec++;
    if (lock_edge !== 16) begin
      n_err++; $display("FAIL reset_relock_edge: got %0d want 16", lock_edge);
    end
    #2 reset = 1;
    #1;
    model_reset();
    n_vec++;
    if (obs !== 21'h0) begin
      n_err++; $display("FAIL reset_locked: got %h want %h", obs, 21'h0);
    end
    reset = 0;
  endtask

  task automatic test_random();
    int p, frames, junk, flip_at, idx;
    bit b;
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      junk    = $urandom_range(0, 3);
      p       = $urandom_range(0, 3);
      frames  = $urandom_range(1, 5);
      flip_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, frames * PAT_W - 1) : -1;
      for (idx = -junk; idx < frames * PAT_W; idx++) begin
        while ($urandom_range(0, 3) == 0) begin
          step(0, 1'($urandom_range(0, 1)));
          n_vec++;
          if (obs !== exp_vec()) begin
            n_err++; $display("FAIL random_idle seg%0d: got %h want %h", seg, obs, exp_vec());
          end
        end
        if (idx < 0) b = 1'($urandom_range(0, 1));
        else begin
          b = pats[p][PAT_W - 1 - (idx % PAT_W)];
          if (idx == flip_at) b = ~b;
        end
        step(1, b);
        n_vec++;
        if (obs !== exp_vec()) begin
          n_err++; $display("FAIL random seg%0d bit%0d: got %h want %h", seg, idx, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    bus.bit_en = 0;
    bus.seq_in = 0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_misaligned();
    test_pattern_change();
    test_corrupt_frame();
    test_gating();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
